// File: rtl/rvsteel_timer_bank_pkg.sv
// Shared register map, bit positions and reset constants for the timer bank
// and its compare channels.
package rvsteel_timer_bank_pkg;

    localparam logic [7:0] ADDR_CR       = 8'h00;
    localparam logic [7:0] ADDR_PRESCALE = 8'h04;
    localparam logic [7:0] ADDR_MTIMEL   = 8'h08;
    localparam logic [7:0] ADDR_MTIMEH   = 8'h0C;
    localparam logic [7:0] ADDR_PENDING  = 8'h10;
    localparam logic [7:0] ADDR_IE       = 8'h14;

    localparam logic [7:0] CH_BASE   = 8'h20;
    localparam logic [7:0] CH_STRIDE = 8'h10;

    localparam int CR_EN_BIT        = 0;
    localparam int CCR_PERIODIC_BIT = 0;

    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        CH_CMPL   = 2'd0,
        CH_CMPH   = 2'd1,
        CH_PERIOD = 2'd2,
        CH_CCR    = 2'd3
    } ch_reg_e;

endpackage

// File: rtl/rvsteel_timer_channel.sv
// One compare channel: 64-bit compare value, optional auto-reload by PERIOD,
// and a sticky pending bit that a match always sets.
module rvsteel_timer_channel
    import rvsteel_timer_bank_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] mtime,
    input  logic        mtime_write,
    input  logic [31:0] write_data,
    input  logic        write_cmpl,
    input  logic        write_cmph,
    input  logic        write_period,
    input  logic        write_ccr,
    input  logic        clear_pending,
    output logic [63:0] cmp,
    output logic [31:0] period,
    output logic        periodic,
    output logic        pending
);

    logic match;

    // Compare is skipped while either operand is being rewritten, which also
    // makes a CMP write win over a reload in the same cycle.
    assign match = !(mtime_write || write_cmpl || write_cmph) && (mtime >= cmp);

    always_ff @(posedge clock) begin
        if (reset) begin
            cmp      <= CMP_RESET;
            period   <= '0;
            periodic <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (write_cmpl)
                cmp[31:0] <= write_data;
            else if (write_cmph)
                cmp[63:32] <= write_data;
            else if (match && periodic)
                cmp <= cmp + {32'd0, period};

            if (write_period)
                period <= write_data;
            if (write_ccr)
                periodic <= write_data[CCR_PERIODIC_BIT];

            if (match)
                pending <= 1'b1;
            else if (clear_pending)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/rvsteel_timer_bank.sv
// Memory-mapped machine timer: prescaled 64-bit time base shared by
// NUM_CHANNELS compare channels, with registered read data and interrupts.
module rvsteel_timer_bank
    import rvsteel_timer_bank_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int PRESCALER_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              rw_address,
    output logic [31:0]             read_data,
    input  logic                    read_request,
    output logic                    read_response,
    input  logic [31:0]             write_data,
    input  logic [3:0]              write_strobe,
    input  logic                    write_request,
    output logic                    write_response,
    output logic                    irq,
    output logic [NUM_CHANNELS-1:0] irq_vector
);

    logic                       en;
    logic [PRESCALER_WIDTH-1:0] prescale;
    logic [PRESCALER_WIDTH-1:0] prescale_count;
    logic                       tick;
    logic [63:0]                mtime;
    logic [NUM_CHANNELS-1:0]    ie;
    logic [NUM_CHANNELS-1:0]    pending;
    logic [NUM_CHANNELS-1:0]    clear_vec;

    logic [63:0] ch_cmp      [NUM_CHANNELS];
    logic [31:0] ch_period   [NUM_CHANNELS];
    logic        ch_periodic [NUM_CHANNELS];

    logic       write_ok;
    logic       wr_cr, wr_prescale, wr_mtimel, wr_mtimeh, wr_pending, wr_ie;
    logic [7:0] ch_offset;
    logic [3:0] ch_sel;
    logic       ch_hit;
    ch_reg_e    ch_reg;

    assign write_ok    = write_request && (rw_address[1:0] == 2'b00) && (write_strobe == 4'hF);
    assign wr_cr       = write_ok && (rw_address == ADDR_CR);
    assign wr_prescale = write_ok && (rw_address == ADDR_PRESCALE);
    assign wr_mtimel   = write_ok && (rw_address == ADDR_MTIMEL);
    assign wr_mtimeh   = write_ok && (rw_address == ADDR_MTIMEH);
    assign wr_pending  = write_ok && (rw_address == ADDR_PENDING);
    assign wr_ie       = write_ok && (rw_address == ADDR_IE);

    assign ch_offset = rw_address - CH_BASE;
    assign ch_sel    = ch_offset[7:4];
    assign ch_hit    = (rw_address >= CH_BASE) && ({28'd0, ch_sel} < 32'(NUM_CHANNELS));
    assign ch_reg    = ch_reg_e'(rw_address[3:2]);

    assign tick      = en && (prescale_count == prescale);
    assign clear_vec = wr_pending ? write_data[NUM_CHANNELS-1:0] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            en             <= 1'b0;
            prescale       <= '0;
            prescale_count <= '0;
            mtime          <= '0;
            ie             <= '0;
        end else begin
            if (wr_cr)
                en <= write_data[CR_EN_BIT];
            if (wr_ie)
                ie <= write_data[NUM_CHANNELS-1:0];

            if (wr_prescale) begin
                prescale       <= write_data[PRESCALER_WIDTH-1:0];
                prescale_count <= '0;
            end else if (tick) begin
                prescale_count <= '0;
            end else if (en) begin
                prescale_count <= prescale_count + 1'b1;
            end

            if (wr_mtimel)
                mtime[31:0] <= write_data;
            else if (wr_mtimeh)
                mtime[63:32] <= write_data;
            else if (tick)
                mtime <= mtime + 64'd1;
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
        logic ch_write;
        assign ch_write = write_ok && ch_hit && (ch_sel == 4'(i));

        rvsteel_timer_channel u_channel (
            .clock         (clock),
            .reset         (reset),
            .mtime         (mtime),
            .mtime_write   (wr_mtimel || wr_mtimeh),
            .write_data    (write_data),
            .write_cmpl    (ch_write && (ch_reg == CH_CMPL)),
            .write_cmph    (ch_write && (ch_reg == CH_CMPH)),
            .write_period  (ch_write && (ch_reg == CH_PERIOD)),
            .write_ccr     (ch_write && (ch_reg == CH_CCR)),
            .clear_pending (clear_vec[i]),
            .cmp           (ch_cmp[i]),
            .period        (ch_period[i]),
            .periodic      (ch_periodic[i]),
            .pending       (pending[i])
        );
    end

    logic        read_hit;
    logic [31:0] read_value;

    always_comb begin
        read_hit   = 1'b0;
        read_value = '0;
        if (rw_address[1:0] == 2'b00) begin
            read_hit = 1'b1;
            case (rw_address)
                ADDR_CR:       read_value[CR_EN_BIT] = en;
                ADDR_PRESCALE: read_value[PRESCALER_WIDTH-1:0] = prescale;
                ADDR_MTIMEL:   read_value = mtime[31:0];
                ADDR_MTIMEH:   read_value = mtime[63:32];
                ADDR_PENDING:  read_value[NUM_CHANNELS-1:0] = pending;
                ADDR_IE:       read_value[NUM_CHANNELS-1:0] = ie;
                default: begin
                    read_hit = ch_hit;
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (ch_sel == 4'(i)) begin
                            case (ch_reg)
                                CH_CMPL:   read_value = ch_cmp[i][31:0];
                                CH_CMPH:   read_value = ch_cmp[i][63:32];
                                CH_PERIOD: read_value = ch_period[i];
                                CH_CCR:    read_value[CCR_PERIODIC_BIT] = ch_periodic[i];
                                default:   read_value = '0;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data      <= '0;
            read_response  <= 1'b0;
            write_response <= 1'b0;
            irq            <= 1'b0;
            irq_vector     <= '0;
        end else begin
            read_response  <= read_request;
            write_response <= write_request;
            if (read_request && read_hit)
                read_data <= read_value;
            irq_vector <= pending & ie;
            irq        <= |(pending & ie);
        end
    end

endmodule

// File: tb/tb_rvsteel_timer_bank.sv
// Directed bench for rvsteel_timer_bank; read expectations go through a
// scoreboard queue and are popped when the read response arrives.
module tb_rvsteel_timer_bank;

    localparam int NCH = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [7:0]     rw_address;
    logic [31:0]    read_data;
    logic           read_request;
    logic           read_response;
    logic [31:0]    write_data;
    logic [3:0]     write_strobe;
    logic           write_request;
    logic           write_response;
    logic           irq;
    logic [NCH-1:0] irq_vector;

    rvsteel_timer_bank #(.NUM_CHANNELS(NCH), .PRESCALER_WIDTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .rw_address     (rw_address),
        .read_data      (read_data),
        .read_request   (read_request),
        .read_response  (read_response),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_request  (write_request),
        .write_response (write_response),
        .irq            (irq),
        .irq_vector     (irq_vector)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    localparam logic [7:0] CR = 8'h00, PRESCALE = 8'h04, MTIMEL = 8'h08, MTIMEH = 8'h0C;
    localparam logic [7:0] PENDING = 8'h10, IE = 8'h14;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        rw_address    = a;
        write_data    = d;
        write_strobe  = s;
        write_request = 1'b1;
        @(posedge clock);
        #1;
        write_request = 1'b0;
        check("write_response", {31'd0, write_response}, 32'd1);
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] e);
        exp_t x;
        sb.push_back('{tag, e});
        rw_address   = a;
        read_request = 1'b1;
        @(posedge clock);
        #1;
        read_request = 1'b0;
        check({tag, "_ack"}, {31'd0, read_response}, 32'd1);
        x = sb.pop_front();
        check(x.tag, read_data, x.value);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rw_address = '0; write_data = '0; write_strobe = '0;
        read_request = 1'b0; write_request = 1'b0;
        idle(3);
        check("rst_irq", {31'd0, irq}, 0);
        check("rst_irq_vector", {28'd0, irq_vector}, 0);
        check("rst_read_data", read_data, 0);
        check("rst_read_response", {31'd0, read_response}, 0);
        check("rst_write_response", {31'd0, write_response}, 0);
        reset = 1'b0;
        idle(1);

        rd("rst_cr", CR, 0);
        rd("rst_prescale", PRESCALE, 0);
        rd("rst_mtimel", MTIMEL, 0);
        rd("rst_mtimeh", MTIMEH, 0);
        rd("rst_pending", PENDING, 0);
        rd("rst_ie", IE, 0);
        rd("rst_ch0_cmpl", 8'h20, 32'hFFFF_FFFF);
        rd("rst_ch3_cmph", 8'h54, 32'hFFFF_FFFF);
        rd("rst_ch1_period", 8'h38, 0);
        rd("rst_ch2_ccr", 8'h4C, 0);

        // prescaler: one tick every 4 cycles over 41 enabled cycles
        wr(PRESCALE, 3, 4'hF);
        rd("prescale_rb", PRESCALE, 3);
        wr(CR, 1, 4'hF);
        idle(40);
        wr(CR, 0, 4'hF);
        rd("presc_mtimel", MTIMEL, 10);
        idle(10);
        rd("frozen_mtimel", MTIMEL, 10);
        rd("frozen_mtimeh", MTIMEH, 0);

        // one-shot level match on channel 0
        wr(PRESCALE, 0, 4'hF);
        wr(MTIMEL, 0, 4'hF);
        wr(MTIMEH, 0, 4'hF);
        wr(8'h24, 0, 4'hF);
        wr(8'h20, 10, 4'hF);
        wr(IE, 1, 4'hF);
        wr(CR, 1, 4'hF);
        idle(11);
        check("oneshot_irq_early", {31'd0, irq}, 0);
        idle(1);
        check("oneshot_irq", {31'd0, irq}, 1);
        check("oneshot_irq_vector", {28'd0, irq_vector}, 1);
        wr(PENDING, 1, 4'hF);
        rd("oneshot_resets", PENDING, 1);
        wr(8'h24, 32'hFFFF_FFFF, 4'hF);
        wr(8'h20, 32'hFFFF_FFFF, 4'hF);
        wr(PENDING, 1, 4'hF);
        check("irq_lag", {31'd0, irq}, 1);
        idle(1);
        check("irq_drop", {31'd0, irq}, 0);
        check("irq_vector_drop", {28'd0, irq_vector}, 0);
        wr(CR, 0, 4'hF);

        // periodic channel 1, mtime advances every 4 cycles
        wr(PRESCALE, 3, 4'hF);
        wr(MTIMEL, 0, 4'hF);
        wr(MTIMEH, 0, 4'hF);
        wr(8'h3C, 1, 4'hF);
        wr(8'h38, 5, 4'hF);
        wr(8'h34, 0, 4'hF);
        wr(8'h30, 5, 4'hF);
        wr(CR, 1, 4'hF);
        idle(22);
        rd("per_pend5", PENDING, 2);
        rd("per_cmp10", 8'h30, 10);
        wr(PENDING, 2, 4'hF);
        rd("per_clr1", PENDING, 0);
        idle(16);
        rd("per_pend10", PENDING, 2);
        rd("per_cmp15", 8'h30, 15);
        wr(PENDING, 2, 4'hF);
        rd("per_clr2", PENDING, 0);
        idle(16);
        rd("per_pend15", PENDING, 2);
        rd("per_cmp20", 8'h30, 20);
        check("per_irq_masked", {31'd0, irq}, 0);
        wr(PENDING, 2, 4'hF);
        wr(CR, 0, 4'hF);
        rd("per_clr3", PENDING, 0);

        // 64-bit reload wrap, isolated to a single match by mtime writes
        wr(PRESCALE, 0, 4'hF);
        wr(8'h38, 4, 4'hF);
        wr(8'h34, 32'hFFFF_FFFF, 4'hF);
        wr(8'h30, 32'hFFFF_FFFE, 4'hF);
        wr(MTIMEH, 32'hFFFF_FFFF, 4'hF);
        wr(MTIMEL, 32'hFFFF_FFFF, 4'hF);
        idle(1);
        wr(MTIMEH, 0, 4'hF);
        wr(MTIMEL, 0, 4'hF);
        rd("wrap_cmpl", 8'h30, 2);
        rd("wrap_cmph", 8'h34, 0);

        // carry into MTIMEH on a single tick
        wr(MTIMEL, 32'hFFFF_FFFF, 4'hF);
        wr(CR, 1, 4'hF);
        wr(CR, 0, 4'hF);
        rd("carry_mtimeh", MTIMEH, 1);
        rd("carry_mtimel", MTIMEL, 0);

        // MTIMEL write beats a coincident tick
        wr(CR, 1, 4'hF);
        wr(MTIMEL, 32'h1234, 4'hF);
        rd("prio_mtimel", MTIMEL, 32'h1234);
        wr(CR, 0, 4'hF);
        rd("prio_after", MTIMEL, 32'h1236);

        // set-versus-clear race on channel 2
        wr(8'h3C, 0, 4'hF);
        wr(8'h34, 32'hFFFF_FFFF, 4'hF);
        wr(8'h30, 32'hFFFF_FFFF, 4'hF);
        wr(PENDING, 32'hF, 4'hF);
        wr(MTIMEH, 0, 4'hF);
        wr(MTIMEL, 0, 4'hF);
        wr(8'h44, 0, 4'hF);
        wr(8'h40, 3, 4'hF);
        rd("race_pre", PENDING, 0);
        wr(CR, 1, 4'hF);
        idle(3);
        wr(PENDING, 4, 4'hF);
        rd("race_set_wins", PENDING, 4);
        wr(CR, 0, 4'hF);

        // illegal writes and reads
        wr(8'h02, 32'hFFFF_FFFF, 4'hF);
        wr(IE, 32'hF, 4'h3);
        wr(PRESCALE, 7, 4'h3);
        rd("ill_cr", CR, 0);
        rd("ill_prescale", PRESCALE, 0);
        rd("ill_ie", IE, 1);
        rd("unmapped_hold", 8'hF0, 1);
        rd("misaligned_hold", 8'h15, 1);

        // unused bits read zero
        wr(8'h4C, 32'hFFFF_FFFF, 4'hF);
        rd("ccr_bits", 8'h4C, 1);
        wr(CR, 32'hFFFF_FFFF, 4'hF);
        rd("cr_bits", CR, 1);

        // reset mid-operation
        wr(IE, 4, 4'hF);
        idle(1);
        check("pre_reset_irq", {31'd0, irq}, 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_reset_irq", {31'd0, irq}, 0);
        check("mid_reset_vector", {28'd0, irq_vector}, 0);
        rd("mid_reset_cr", CR, 0);
        rd("mid_reset_mtimel", MTIMEL, 0);
        rd("mid_reset_pending", PENDING, 0);
        rd("mid_reset_ie", IE, 0);
        rd("mid_reset_ch2_cmpl", 8'h40, 32'hFFFF_FFFF);
        rd("mid_reset_ch2_ccr", 8'h4C, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
